frame_scanout: RTL and testbench

//  Parametrised frame-buffer scanout engine between the frame buffer RAM and the VGA DACs.

---
 rtl/frame_scanout.sv | 84 ++++++++
 tb/tb_frame_scanout.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/frame_scanout.sv
// frame_scanout: frame-buffer scanout with integer up-scaling, two display pages, 3-3-2 or palette colour, vblank-deferred page flips
// Ports: Clk/Reset (async, active-high); pixel_clk level sampled in Clk; DrawX/DrawY beam position;
//   frame_rdAddress/frame_output frame RAM read port (data 1 Clk after address); pal_mode/pal_we/pal_addr/pal_data palette;
//   swap_req/swap_done/disp_page page flipping; Red/Green/Blue DAC outputs
module frame_scanout #(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int SCALE_SH = 2,
  parameter int ADDR_W = 19,
  parameter int PAL_AW = 8,
  parameter int SWAP_LINE = 480,
  parameter logic [23:0] BORDER = 24'h000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pixel_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] frame_rdAddress,
  input  logic [7:0]        frame_output,
  input  logic              pal_mode,
  input  logic              pal_we,
  input  logic [PAL_AW-1:0] pal_addr,
  input  logic [23:0]       pal_data,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              disp_page,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue
);
  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;
  localparam logic [10:0] WIN_W = 11'(FB_W << SCALE_SH);
  localparam logic [10:0] WIN_H = 11'(FB_H << SCALE_SH);
  localparam logic [ADDR_W:0] PAGE_SZ = (ADDR_W+1)'(FB_W * FB_H);
  localparam logic [ADDR_W:0] ROW_SZ = (ADDR_W+1)'(FB_W);
  localparam logic [9:0] SWAP_Y = 10'(SWAP_LINE);
  state_t st;
  logic pix_d, pix_tick, in_win, commit, v0, v1, w0, w1;
  logic [7:0] d1;
  logic [ADDR_W:0] addr_n;
  logic [23:0] pal [2**PAL_AW];
  logic [23:0] direct, rgb_n;
  assign pix_tick = pixel_clk & ~pix_d;
  assign in_win = ({1'b0, DrawX} < WIN_W) && ({1'b0, DrawY} < WIN_H);
  assign commit = pix_tick && DrawY == SWAP_Y && DrawX == 10'd0;
  assign addr_n = (disp_page ? PAGE_SZ : '0) + (ADDR_W+1)'(DrawY >> SCALE_SH) * ROW_SZ + (ADDR_W+1)'(DrawX >> SCALE_SH);
  assign direct = {d1[7:5], d1[7:5], d1[7:6], d1[4:2], d1[4:2], d1[4:3], {4{d1[1:0]}}};
  // palette read is combinational off the register array, so a same-cycle write is seen only afterwards
  assign rgb_n = !w1 ? BORDER : pal_mode ? pal[PAL_AW'(d1)] : direct;
  always_ff @(posedge Clk)
    if (pal_we) pal[pal_addr] <= pal_data;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      pix_d <= 1'b0;
      frame_rdAddress <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      w0 <= 1'b0;
      w1 <= 1'b0;
      d1 <= '0;
      {Red, Green, Blue} <= '0;
      disp_page <= 1'b0;
      swap_done <= 1'b0;
      st <= IDLE;
    end else begin
      pix_d <= pixel_clk;
      v0 <= pix_tick;
      v1 <= v0;
      if (pix_tick) begin
        w0 <= in_win;
        if (in_win) frame_rdAddress <= addr_n[ADDR_W-1:0];
      end
      if (v0) begin
        d1 <= frame_output;
        w1 <= w0;
      end
      if (v1) {Red, Green, Blue} <= rgb_n;
      // requests outside IDLE are absorbed; a request coinciding with the swap line waits a full frame
      st <= st == IDLE ? (swap_req ? PENDING : IDLE) : st == PENDING ? (commit ? COMMIT : PENDING) : IDLE;
      swap_done <= st == COMMIT;
      if (st == COMMIT) disp_page <= ~disp_page;
    end
endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: scoreboard bench for frame_scanout with directed pixel vectors
module tb_frame_scanout;
  logic Clk = 1'b0, Reset = 1'b1, pixel_clk = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic [18:0] frame_rdAddress;
  logic [7:0] frame_output;
  logic pal_mode = 1'b0, pal_we = 1'b0, swap_req = 1'b0;
  logic [7:0] pal_addr = '0;
  logic [23:0] pal_data = '0;
  logic swap_done, disp_page;
  logic [7:0] Red, Green, Blue;
  logic [7:0] ram [0:38399];
  logic [23:0] exp_q [$];
  int n_chk = 0, n_fail = 0, sd_cnt = 0, base;
  logic [2:0] sh = '0;
  logic prv = 1'b0, tk;
  frame_scanout dut (
    .Clk(Clk), .Reset(Reset), .pixel_clk(pixel_clk), .DrawX(DrawX), .DrawY(DrawY),
    .frame_rdAddress(frame_rdAddress), .frame_output(frame_output), .pal_mode(pal_mode),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data), .swap_req(swap_req),
    .swap_done(swap_done), .disp_page(disp_page), .Red(Red), .Green(Green), .Blue(Blue)
  );
  always #10 Clk = ~Clk;
  assign frame_output = (frame_rdAddress < 19'd38400) ? ram[frame_rdAddress] : 8'h00;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge Clk)
    if (Reset) begin
      sh = '0;
      prv = 1'b0;
    end else begin
      if (sh[2]) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rgb: got %h expected nothing (queue empty)", {Red, Green, Blue});
        end else chk("rgb", {8'h0, Red, Green, Blue}, {8'h0, exp_q.pop_front()});
      end
      tk = pixel_clk & ~prv;
      prv = pixel_clk;
      sh = {sh[1:0], tk};
    end
  always @(negedge Clk) if (swap_done) sd_cnt++;
  task automatic px(input int x, input int y, input logic [23:0] e);
    @(posedge Clk);
    #1 DrawX = 10'(x);
    DrawY = 10'(y);
    pixel_clk = 1'b1;
    exp_q.push_back(e);
    repeat (2) @(posedge Clk);
    #1 pixel_clk = 1'b0;
    repeat (2) @(posedge Clk);
  endtask
  task automatic req();
    @(posedge Clk);
    #1 swap_req = 1'b1;
    @(posedge Clk);
    #1 swap_req = 1'b0;
  endtask
  task automatic pal_wr(input logic [7:0] a, input logic [23:0] d);
    @(posedge Clk);
    #1 pal_we = 1'b1;
    pal_addr = a;
    pal_data = d;
    @(posedge Clk);
    #1 pal_we = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 38400; i++) ram[i] = 8'h00;
    ram[0] = 8'hE3;
    ram[1] = 8'hB6;
    ram[2] = 8'h12;
    ram[161] = 8'h1C;
    ram[19199] = 8'h49;
    ram[19361] = 8'h03;
    repeat (3) @(posedge Clk);
    #1 chk("reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
    chk("reset_addr", 32'(frame_rdAddress), 32'h0);
    chk("reset_page", 32'(disp_page), 32'h0);
    chk("reset_done", 32'(swap_done), 32'h0);
    Reset = 1'b0;
    px(0, 0, 24'hFF00FF);
    px(7, 5, 24'h00FF00);
    chk("addr_7_5", 32'(frame_rdAddress), 32'd161);
    px(640, 5, 24'h000000);
    chk("addr_hold", 32'(frame_rdAddress), 32'd161);
    px(639, 479, 24'h494955);
    chk("addr_last", 32'(frame_rdAddress), 32'd19199);
    px(0, 480, 24'h000000);
    px(4, 0, 24'hB6B6AA);
    px(8, 0, 24'h0092AA);
    pal_wr(8'h12, 24'h123456);
    pal_mode = 1'b1;
    px(8, 0, 24'h123456);
    @(posedge Clk);
    #1 DrawX = 10'd8;
    DrawY = 10'd0;
    pixel_clk = 1'b1;
    exp_q.push_back(24'h123456);
    repeat (2) @(posedge Clk);
    #1 pixel_clk = 1'b0;
    pal_we = 1'b1;
    pal_addr = 8'h12;
    pal_data = 24'hABCDEF;
    @(posedge Clk);
    #1 pal_we = 1'b0;
    @(posedge Clk);
    px(8, 0, 24'hABCDEF);
    pal_mode = 1'b0;
    base = sd_cnt;
    px(0, 100, 24'h000000);
    req();
    chk("page_pending", 32'(disp_page), 32'h0);
    px(0, 479, 24'h000000);
    chk("page_before_line", 32'(disp_page), 32'h0);
    chk("done_before_line", 32'(sd_cnt - base), 32'd0);
    px(0, 480, 24'h000000);
    chk("page_flipped", 32'(disp_page), 32'h1);
    chk("done_once", 32'(sd_cnt - base), 32'd1);
    px(7, 5, 24'h0000FF);
    chk("addr_page1", 32'(frame_rdAddress), 32'd19361);
    req();
    px(0, 10, 24'h000000);
    req();
    px(0, 20, 24'h000000);
    req();
    px(0, 480, 24'h000000);
    chk("multi_page", 32'(disp_page), 32'h0);
    chk("multi_done", 32'(sd_cnt - base), 32'd2);
    px(0, 480, 24'h000000);
    chk("no_extra_page", 32'(disp_page), 32'h0);
    chk("no_extra_done", 32'(sd_cnt - base), 32'd2);
    px(7, 5, 24'h00FF00);
    req();
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1 chk("midreset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
    chk("midreset_page", 32'(disp_page), 32'h0);
    chk("midreset_addr", 32'(frame_rdAddress), 32'h0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    px(0, 480, 24'h000000);
    chk("post_reset_page", 32'(disp_page), 32'h0);
    chk("post_reset_done", 32'(sd_cnt - base), 32'd2);
    px(0, 0, 24'hFF00FF);
    repeat (5) @(posedge Clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
